// File: rtl/seg_display_monitor.sv
// Decodes the multiplexed active-low 7-segment/anode scan back into four hex digits with valid flags.
// Latency: SETTLE_CYCLES+1 clocks from a stable input pair to registered digit/strobe outputs.
// No backpressure: inputs are sampled every cycle and pulses are single-cycle, never held off.
module seg_display_monitor #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        seg_error,
    output logic        an_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Returns {legal, nibble} for an active-low gfedcba pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  digit_valid_q, digit_valid_d;
    logic [3:0]  cap_mask_q, cap_mask_d;
    logic        frame_done_q, frame_done_d;
    logic        seg_error_q, seg_error_d;
    logic        an_error_q, an_error_d;

    logic        changed;
    logic        capture;
    logic [3:0]  an_sel;
    logic        an_onehot;
    logic        an_multi;
    logic [4:0]  dec;
    logic        seg_blank;
    logic [3:0]  mask_next;

    // The capture acts on the registered pair, which equals the incoming pair whenever capture fires.
    assign changed   = (seg != seg_q) || (an != an_q);
    assign an_sel    = ~an_q;
    assign an_onehot = (an_sel != 4'h0) && ((an_sel & 4'(an_sel - 4'd1)) == 4'h0);
    assign an_multi  = (an_sel != 4'h0) && !an_onehot;
    assign dec       = decode_glyph(seg_q);
    assign seg_blank = (seg_q == SEG_BLANK);
    // Fires only on the step into saturation, so each stable period captures once.
    assign capture   = !changed && (state_q != HOLD) && (cnt_q == SETTLE_MAX - 8'd1);

    // Stability tracking, decode and frame bookkeeping for the next edge.
    always_comb begin
        seg_d         = seg;
        an_d          = an;
        cnt_d         = cnt_q;
        state_d       = state_q;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        cap_mask_d    = cap_mask_q;
        frame_done_d  = 1'b0;
        seg_error_d   = 1'b0;
        an_error_d    = 1'b0;
        mask_next     = cap_mask_q | an_sel;

        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q != SETTLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (changed) begin
            state_d = IDLE;
        end else if (cnt_d == SETTLE_MAX) begin
            state_d = HOLD;
        end else begin
            state_d = SETTLE;
        end

        if (capture && an_multi) begin
            an_error_d = 1'b1;
        end

        if (capture && an_onehot) begin
            for (int i = 0; i < 4; i++) begin
                if (an_sel[i]) begin
                    digits_d[4*i +: 4] = dec[4] ? dec[3:0] : 4'h0;
                    digit_valid_d[i]   = dec[4];
                end
            end
            seg_error_d = !dec[4] && !seg_blank;
            if (mask_next == 4'hF) begin
                frame_done_d = 1'b1;
                cap_mask_d   = 4'h0;
            end else begin
                cap_mask_d   = mask_next;
            end
        end
    end

    // All state and outputs are registered; reset clears any partial settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            seg_q         <= SEG_BLANK;
            an_q          <= 4'hF;
            cnt_q         <= 8'd0;
            digits_q      <= 16'h0000;
            digit_valid_q <= 4'h0;
            cap_mask_q    <= 4'h0;
            frame_done_q  <= 1'b0;
            seg_error_q   <= 1'b0;
            an_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            cap_mask_q    <= cap_mask_d;
            frame_done_q  <= frame_done_d;
            seg_error_q   <= seg_error_d;
            an_error_q    <= an_error_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign frame_done  = frame_done_q;
    assign seg_error   = seg_error_q;
    assign an_error    = an_error_q;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Bench for seg_display_monitor: directed scenarios plus randomized scan against a run-length model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// No backpressure involved; every wait is a fixed number of cycles.
module tb_seg_display_monitor;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        seg_error;
    logic        an_error;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int ae_cnt = 0;
    int fd_last = -1;
    int se_last = -1;
    int ae_last = -1;

    seg_display_monitor #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .seg_error  (seg_error),
        .an_error   (an_error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A pair is captured when it has been seen on exactly SETTLE+1 consecutive edges.
    // Reset counts as one sighting of the blank / no-anode pair.
    logic [6:0] run_seg;
    logic [3:0] run_an;
    int         run_len;
    logic [3:0] m_dig [4];
    logic [3:0] m_val;
    logic [3:0] m_mask;
    logic       m_fd, m_se, m_ae;

    function automatic logic [6:0] glyph_of(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic int glyph_index(input logic [6:0] s);
        for (int n = 0; n < 16; n++) if (glyph_of(n) == s) return n;
        return -1;
    endfunction

    function automatic logic [15:0] m_digits();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    task automatic model_reset();
        run_seg = 7'h7F; run_an = 4'hF; run_len = 1;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val = 4'h0; m_mask = 4'h0;
        m_fd = 1'b0; m_se = 1'b0; m_ae = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic [3:0] a);
        int lows;
        int pos;
        int g;
        m_fd = 1'b0; m_se = 1'b0; m_ae = 1'b0;
        if (s == run_seg && a == run_an) run_len++;
        else begin run_seg = s; run_an = a; run_len = 1; end
        if (run_len == SETTLE + 1) begin
            lows = 0; pos = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; pos = i; end
            if (lows > 1) m_ae = 1'b1;
            else if (lows == 1) begin
                g = glyph_index(s);
                if (g >= 0) begin m_dig[pos] = 4'(g); m_val[pos] = 1'b1; end
                else begin
                    m_dig[pos] = 4'h0; m_val[pos] = 1'b0;
                    if (s != 7'h7F) m_se = 1'b1;
                end
                m_mask[pos] = 1'b1;
                if (m_mask == 4'hF) begin m_fd = 1'b1; m_mask = 4'h0; end
            end
        end
    endtask

    // ---------------- drivers ----------------
    // One clock with the given pair; records pulses seen after the edge.
    task automatic cyc(input logic [6:0] s, input logic [3:0] a);
        seg = s; an = a;
        @(posedge clk);
        #1;
        cyc_n++;
        model_step(s, a);
        if (frame_done) begin fd_cnt++; fd_last = cyc_n; end
        if (seg_error)  begin se_cnt++; se_last = cyc_n; end
        if (an_error)   begin ae_cnt++; ae_last = cyc_n; end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(s, a);
    endtask

    task automatic do_reset();
        rst = 1'b1; seg = 7'h7F; an = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        fd_cnt = 0; se_cnt = 0; ae_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hold(7'h79, 4'b1110, 6);
        #3; rst = 1'b1; #1;
        n_cmp++;
        if ({digits, digit_valid, frame_done, seg_error, an_error} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_async: got digits=%h valid=%b fd=%b se=%b ae=%b, want all 0",
                     digits, digit_valid, frame_done, seg_error, an_error);
        end
        #1; rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_digit();
        do_reset();
        for (int e = 0; e <= 4; e++) begin
            cyc(7'h19, 4'b1110);
            n_cmp++;
            if (e < 4 && (digits !== 16'h0 || digit_valid !== 4'h0)) begin
                n_fail++;
                $display("FAIL single_early e=%0d: got %h/%b, want 0000/0000", e, digits, digit_valid);
            end else if (e == 4 && (digits !== 16'h0004 || digit_valid !== 4'b0001)) begin
                n_fail++;
                $display("FAIL single_capture: got %h/%b, want 0004/0001", digits, digit_valid);
            end
        end
        hold(7'h19, 4'b1110, 10);
        n_cmp++;
        if (digits !== 16'h0004 || digit_valid !== 4'b0001 || se_cnt != 0 || ae_cnt != 0 || fd_cnt != 0) begin
            n_fail++;
            $display("FAIL single_hold: got %h/%b pulses fd=%0d se=%0d ae=%0d, want 0004/0001 no pulses",
                     digits, digit_valid, fd_cnt, se_cnt, ae_cnt);
        end
    endtask

    task automatic test_full_frame();
        logic [6:0] pats [4];
        int exp_cyc;
        pats[0] = 7'h0E; pats[1] = 7'h08; pats[2] = 7'h46; pats[3] = 7'h00;
        exp_cyc = -1;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 8; i++) begin
                cyc(pats[d], ~(4'b0001 << d));
                if (d == 3 && i == SETTLE) exp_cyc = cyc_n;
            end
        end
        n_cmp++;
        if (digits !== 16'h8CAF || digit_valid !== 4'hF) begin
            n_fail++;
            $display("FAIL frame_value: got %h/%b, want 8CAF/1111", digits, digit_valid);
        end
        n_cmp++;
        if (fd_cnt != 1 || fd_last != exp_cyc) begin
            n_fail++;
            $display("FAIL frame_pulse: got %0d cycles high, last at %0d, want 1 at %0d", fd_cnt, fd_last, exp_cyc);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(7'h30, 4'b1101, 3);
        cyc(7'h31, 4'b1101);
        for (int e = 0; e <= 4; e++) begin
            cyc(7'h30, 4'b1101);
            n_cmp++;
            if (e < 4 && digits[7:4] !== 4'h0) begin
                n_fail++;
                $display("FAIL glitch_early e=%0d: got digit1=%h, want 0", e, digits[7:4]);
            end else if (e == 4 && (digits[7:4] !== 4'h3 || digit_valid[1] !== 1'b1)) begin
                n_fail++;
                $display("FAIL glitch_capture: got digit1=%h valid=%b, want 3/1", digits[7:4], digit_valid[1]);
            end
        end
        n_cmp++;
        if (se_cnt != 0) begin
            n_fail++;
            $display("FAIL glitch_seg_error: got %0d pulses, want 0", se_cnt);
        end
    endtask

    task automatic test_errors();
        int exp_cyc;
        do_reset();
        hold(7'h12, 4'b1110, 6);
        hold(7'h24, 4'b1011, 6);
        n_cmp++;
        if (digits !== 16'h0205 || digit_valid !== 4'b0101) begin
            n_fail++;
            $display("FAIL err_preload: got %h/%b, want 0205/0101", digits, digit_valid);
        end
        exp_cyc = cyc_n + SETTLE + 1;
        hold(7'h31, 4'b1011, 8);
        n_cmp++;
        if (se_cnt != 1 || se_last != exp_cyc || digits !== 16'h0005 || digit_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_illegal: got se=%0d at %0d %h/%b, want 1 at %0d 0005/0001",
                     se_cnt, se_last, digits, digit_valid, exp_cyc);
        end
        hold(7'h7F, 4'b1011, 8);
        n_cmp++;
        if (se_cnt != 1 || digits[11:8] !== 4'h0 || digit_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_blank: got se=%0d %h/%b, want se 1 (no new) 0005/0001", se_cnt, digits, digit_valid);
        end
        exp_cyc = cyc_n + SETTLE + 1;
        hold(7'h00, 4'b1100, 8);
        n_cmp++;
        if (ae_cnt != 1 || ae_last != exp_cyc || digits !== 16'h0005 || digit_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_anode: got ae=%0d at %0d %h/%b, want 1 at %0d 0005/0001",
                     ae_cnt, ae_last, digits, digit_valid, exp_cyc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(7'h19, 4'b1110, 6);
        hold(7'h30, 4'b1101, 6);
        hold(7'h24, 4'b1011, 6);
        hold(7'h79, 4'b0111, 6);
        n_cmp++;
        if (digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL rstmid_preload: got %h, want 1234", digits);
        end
        hold(7'h02, 4'b0111, 2);
        #3; rst = 1'b1; #1;
        n_cmp++;
        if ({digits, digit_valid, frame_done, seg_error, an_error} !== 23'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %h/%b fd=%b se=%b ae=%b, want all 0",
                     digits, digit_valid, frame_done, seg_error, an_error);
        end
        #1; rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 5; e++) begin
            cyc(7'h02, 4'b0111);
            n_cmp++;
            if (e < 5 && digits !== 16'h0) begin
                n_fail++;
                $display("FAIL rstmid_early e=%0d: got %h, want 0000", e, digits);
            end else if (e == 5 && (digits !== 16'h6000 || digit_valid !== 4'b1000)) begin
                n_fail++;
                $display("FAIL rstmid_capture: got %h/%b, want 6000/1000", digits, digit_valid);
            end
        end
    endtask

    task automatic test_partial_frame();
        int order [5];
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1; order[4] = 2;
        do_reset();
        for (int k = 0; k < 5; k++) hold(glyph_of(k + 1), ~(4'b0001 << order[k]), 6);
        n_cmp++;
        if (fd_cnt != 0) begin
            n_fail++;
            $display("FAIL partial_no_frame: got %0d pulses, want 0", fd_cnt);
        end
        hold(glyph_of(9), 4'b0111, 6);
        n_cmp++;
        if (fd_cnt != 1) begin
            n_fail++;
            $display("FAIL partial_complete: got %0d pulses, want 1", fd_cnt);
        end
        for (int d = 0; d < 3; d++) hold(glyph_of(d + 10), ~(4'b0001 << d), 6);
        n_cmp++;
        if (fd_cnt != 1) begin
            n_fail++;
            $display("FAIL partial_restart: got %0d pulses after 3 digits, want 1", fd_cnt);
        end
        hold(glyph_of(14), 4'b0111, 6);
        n_cmp++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL partial_second_frame: got %0d pulses, want 2", fd_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [3:0] a;
        int r;
        int len;
        do_reset();
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) a = 4'hF;
            else begin
                a = 4'($urandom);
                while ($countones(a) > 2) a = 4'($urandom);
            end
            r = $urandom_range(0, 7);
            if (r < 6)       s = glyph_of($urandom_range(0, 15));
            else if (r == 6) s = 7'h7F;
            else             s = 7'($urandom);
            len = $urandom_range(1, SETTLE + 4);
            for (int i = 0; i < len; i++) begin
                cyc(s, a);
                n_cmp++;
                if (digits !== m_digits() || digit_valid !== m_val ||
                    frame_done !== m_fd || seg_error !== m_se || an_error !== m_ae) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d: got %h/%b fd=%b se=%b ae=%b, want %h/%b fd=%b se=%b ae=%b",
                             cyc_n, digits, digit_valid, frame_done, seg_error, an_error,
                             m_digits(), m_val, m_fd, m_se, m_ae);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({digits, digit_valid, frame_done, seg_error, an_error} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b fd=%b se=%b ae=%b, want all 0",
                     digits, digit_valid, frame_done, seg_error, an_error);
        end
        rst = 1'b0;
        test_reset();
        test_single_digit();
        test_full_frame();
        test_glitch();
        test_errors();
        test_reset_mid();
        test_partial_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
